// File: rtl/imm_decode_stage.sv
// ---------------------------------------------------------------------------
// imm_decode_stage
//
// Pipelined immediate generator for the RV32I datapath. A 32-bit instruction
// is decoded combinationally on the input side (format resolution plus
// immediate construction), then carried through DEPTH elastic register
// slices together with its format code, illegal flag and sideband tag.
//
// Parameters
//   XLEN        output immediate width (32 or 64)
//   DEPTH       number of register slices (1..4)
//   AUTO_DECODE 1: format decoded from instr[6:0]; 0: taken from in_imm_src
//   TAG_W       width of the sideband tag
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake (in_ready is combinational from out_ready)
//   in_instr        raw instruction
//   in_imm_src      explicit format code (000 I,001 S,010 B,011 J,100 U,101 R)
//   in_tag          sideband, passed through unchanged
//   out_valid/ready output handshake
//   out_imm         sign-extended immediate (0 for R and illegal)
//   out_fmt         resolved format code, 111 = illegal
//   out_illegal     unknown opcode or format code
//   out_tag         tag matching out_imm
//   illegal_count   saturating count of illegal instructions delivered
// ---------------------------------------------------------------------------
module imm_decode_stage #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1,
  parameter int AUTO_DECODE = 1,
  parameter int TAG_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_count
);

  localparam logic [2:0] FMT_I   = 3'b000;
  localparam logic [2:0] FMT_S   = 3'b001;
  localparam logic [2:0] FMT_B   = 3'b010;
  localparam logic [2:0] FMT_J   = 3'b011;
  localparam logic [2:0] FMT_U   = 3'b100;
  localparam logic [2:0] FMT_R   = 3'b101;
  localparam logic [2:0] FMT_BAD = 3'b111;

  // -------------------------------------------------------------------------
  // Input-side decode
  // -------------------------------------------------------------------------
  logic [6:0]        opcode;
  logic [2:0]        dec_fmt;
  logic [2:0]        sel_fmt;
  logic              dec_illegal;
  logic [2:0]        dec_fmt_res;
  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]   dec_imm;

  assign opcode = in_instr[6:0];

  always_comb begin
    dec_fmt = FMT_BAD;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
      7'b0100011:                                     dec_fmt = FMT_S;
      7'b1100011:                                     dec_fmt = FMT_B;
      7'b1101111:                                     dec_fmt = FMT_J;
      7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
      7'b0110011:                                     dec_fmt = FMT_R;
      default:                                        dec_fmt = FMT_BAD;
    endcase
  end

  // Both sources stay referenced so either build mode elaborates cleanly.
  assign sel_fmt     = (AUTO_DECODE != 0) ? dec_fmt : in_imm_src;
  // Codes 110 and 111 are both illegal; they are reported uniformly as 111.
  assign dec_illegal = (sel_fmt[2:1] == 2'b11);
  assign dec_fmt_res = dec_illegal ? FMT_BAD : sel_fmt;

  always_comb begin
    dec_imm32 = '0;
    case (dec_fmt_res)
      FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      FMT_U: dec_imm32 = {in_instr[31:12], 12'b0};
      default: dec_imm32 = '0;
    endcase
  end

  // Signed cast sign-extends bit 31 up to XLEN (no-op when XLEN is 32).
  assign dec_imm = XLEN'(dec_imm32);

  // -------------------------------------------------------------------------
  // Elastic slice chain
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] vld_reg;
  logic [XLEN-1:0]  imm_reg [DEPTH];
  logic [2:0]       fmt_reg [DEPTH];
  logic [DEPTH-1:0] ill_reg;
  logic [TAG_W-1:0] tag_reg [DEPTH];
  logic [15:0]      cnt_reg;
  logic [DEPTH-1:0] load;

  // Slice k can load when it is empty or its contents leave this cycle.
  // Unrolling that recursion: slice k loads unless slices k..DEPTH-1 are all
  // full and the output is stalled. Written flat to avoid a combinational
  // chain through the same vector.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_load
      localparam logic [DEPTH-1:0] LOW_MASK = DEPTH'((1 << gi) - 1);
      assign load[gi] = out_ready | ~(&(vld_reg | LOW_MASK));
    end
  endgenerate

  assign in_ready = load[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg <= '0;
      ill_reg <= '0;
      cnt_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        imm_reg[k] <= '0;
        fmt_reg[k] <= '0;
        tag_reg[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld_reg[0] <= in_valid;
        if (in_valid) begin
          imm_reg[0] <= dec_imm;
          fmt_reg[0] <= dec_fmt_res;
          ill_reg[0] <= dec_illegal;
          tag_reg[0] <= in_tag;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          vld_reg[k] <= vld_reg[k-1];
          if (vld_reg[k-1]) begin
            imm_reg[k] <= imm_reg[k-1];
            fmt_reg[k] <= fmt_reg[k-1];
            ill_reg[k] <= ill_reg[k-1];
            tag_reg[k] <= tag_reg[k-1];
          end
        end
      end
      if (vld_reg[DEPTH-1] && out_ready && ill_reg[DEPTH-1] && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign out_valid     = vld_reg[DEPTH-1];
  assign out_imm       = imm_reg[DEPTH-1];
  assign out_fmt       = fmt_reg[DEPTH-1];
  assign out_illegal   = ill_reg[DEPTH-1];
  assign out_tag       = tag_reg[DEPTH-1];
  assign illegal_count = cnt_reg;

endmodule
